// File: rtl/serial_circular_rotator.sv
// Variable-amount circular rotator that steps one bit per clock, with valid/ready on both sides.
// Define ROTATOR_DOUBLE_STEP_EN to rotate two positions per cycle while two or more steps remain.
module serial_circular_rotator #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [AW-1:0] up_amount,
    input  logic          up_dir,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // state | meaning
    // IDLE  | ready for a new word; inputs sampled only here
    // SHIFT | rotating the working register, counter counts down to zero
    // DONE  | result presented, held until the consumer takes it
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;

    function automatic logic [N-1:0] rot1(input logic [N-1:0] r, input logic right);
        return right ? {r[0], r[N-1:1]} : {r[N-2:0], r[N-1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        case (state_q)
            IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    data_d  = up_data;
                    cnt_d   = up_amount;
                    dir_d   = up_dir;
                    state_d = (up_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef ROTATOR_DOUBLE_STEP_EN
                if (int'(cnt_q) >= 2) begin
                    data_d = rot1(rot1(data_q, dir_q), dir_q);
                    cnt_d  = cnt_q - AW'(1) - AW'(1);
                end else begin
                    data_d = rot1(data_q, dir_q);
                    cnt_d  = cnt_q - AW'(1);
                end
`else
                data_d = rot1(data_q, dir_q);
                cnt_d  = cnt_q - AW'(1);
`endif
                if (cnt_d == '0) state_d = DONE;
            end
            DONE: begin
                down_valid = 1'b1;
                if (down_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holds the last result after DONE; only meaningful while down_valid is high.
    assign down_data = data_q;

endmodule

// File: tb/tb_serial_circular_rotator.sv
// Directed and randomized checks of serial_circular_rotator (N = 8); inputs driven and outputs
// sampled on the falling clock edge.
module tb_serial_circular_rotator;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [AW-1:0] up_amount;
    logic          up_dir;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    int checks = 0;
    int errors = 0;

    serial_circular_rotator #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amount  (up_amount),
        .up_dir     (up_dir),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_rot(input logic [N-1:0] a, input int amt, input logic right);
        int s;
        s = amt % N;
        if (s == 0) return a;
        return right ? ((a >> s) | (a << (N - s))) : ((a << s) | (a >> (N - s)));
    endfunction

    function automatic int exp_lat(input int amt);
`ifdef ROTATOR_DOUBLE_STEP_EN
        return (amt + 1) / 2 + 1;
`else
        return amt + 1;
`endif
    endfunction

    // Presents one operation, then waits (bounded) for down_valid; returns falling edges counted
    // from the accepting rising edge. Leaves down_ready low.
    task automatic send_op(input logic [N-1:0] d, input logic [AW-1:0] a, input logic dr,
                           output int lat, output bit timeout);
        int w;
        w = 0;
        while (!up_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        up_valid  = 1'b1;
        up_data   = d;
        up_amount = a;
        up_dir    = dr;
        @(posedge clk);
        @(negedge clk);
        up_valid  = 1'b0;
        up_data   = $urandom();
        up_amount = AW'($urandom());
        up_dir    = $urandom_range(0, 1) == 1;
        lat = 1;
        while (!down_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        timeout = !down_valid;
    endtask

    task automatic release_result();
        down_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        down_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
        checks++;
        if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid got %b want 0", down_valid); end
        checks++;
        if (down_data !== 8'h00) begin errors++; $display("FAIL reset_down_data got %h want 00", down_data); end
    endtask

    task automatic test_left();
        int lat; bit to;
        send_op(8'b1011_0001, 3'd3, 1'b0, lat, to);
        checks++;
        if (to || down_data !== 8'b1000_1101) begin errors++; $display("FAIL left_data got %b want 10001101", down_data); end
        checks++;
        if (lat != exp_lat(3)) begin errors++; $display("FAIL left_latency got %0d want %0d", lat, exp_lat(3)); end
        release_result();
        checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
            errors++; $display("FAIL left_return_idle got ready=%b valid=%b want 1 0", up_ready, down_valid);
        end
    endtask

    task automatic test_right();
        int lat; bit to;
        send_op(8'b1011_0001, 3'd3, 1'b1, lat, to);
        checks++;
        if (to || down_data !== 8'b0011_0110) begin errors++; $display("FAIL right_data got %b want 00110110", down_data); end
        checks++;
        if (lat != exp_lat(3)) begin errors++; $display("FAIL right_latency got %0d want %0d", lat, exp_lat(3)); end
        release_result();
    endtask

    task automatic test_amount_edges();
        int lat; bit to;
        send_op(8'hA5, 3'd0, 1'b0, lat, to);
        checks++;
        if (to || down_data !== 8'hA5) begin errors++; $display("FAIL zero_data got %h want a5", down_data); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
        release_result();
        send_op(8'b1011_0001, 3'd7, 1'b1, lat, to);
        checks++;
        if (to || down_data !== 8'b0110_0011) begin errors++; $display("FAIL max_amount_data got %b want 01100011", down_data); end
        checks++;
        if (lat != exp_lat(7)) begin errors++; $display("FAIL max_amount_latency got %0d want %0d", lat, exp_lat(7)); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        send_op(8'h3C, 3'd2, 1'b0, lat, to);
        checks++;
        if (to || down_data !== 8'hF0) begin errors++; $display("FAIL bp_data got %h want f0", down_data); end
        for (int i = 0; i < 5; i++) begin
            up_valid  = (i % 2) == 0;
            up_data   = 8'h11 * 8'(i + 1);
            up_amount = 3'd1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (down_valid !== 1'b1 || down_data !== 8'hF0 || up_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b want 1 f0 0",
                         i, down_valid, down_data, up_ready);
            end
        end
        up_valid = 1'b0;
        release_result();
        checks++;
        if (down_valid !== 1'b0 || up_ready !== 1'b1 || down_data !== 8'hF0) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b data=%h want 0 1 f0", down_valid, up_ready, down_data);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat; bit to; bit seen;
        up_valid  = 1'b1;
        up_data   = 8'h81;
        up_amount = 3'd6;
        up_dir    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_state got ready=%b valid=%b data=%h want 1 0 00", up_ready, down_valid, down_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (down_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_result got valid seen=1 want 0"); end
        send_op(8'h81, 3'd6, 1'b0, lat, to);
        checks++;
        if (to || down_data !== 8'h60) begin errors++; $display("FAIL midrst_after_data got %h want 60", down_data); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat; bit to; int hold;
        logic [N-1:0] d, exp;
        logic [AW-1:0] a;
        logic dr;
        for (int k = 0; k < 200; k++) begin
            d  = N'($urandom());
            a  = AW'($urandom());
            dr = $urandom_range(0, 1) == 1;
            exp = ref_rot(d, int'(a), dr);
            send_op(d, a, dr, lat, to);
            checks++;
            if (to || down_data !== exp || lat != exp_lat(int'(a))) begin
                errors++;
                $display("FAIL rand op %0d d=%h a=%0d dir=%b got %h lat %0d want %h lat %0d",
                         k, d, a, dr, down_data, lat, exp, exp_lat(int'(a)));
            end
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checks++;
                if (down_valid !== 1'b1 || down_data !== exp) begin
                    errors++;
                    $display("FAIL rand_hold op %0d got valid=%b data=%h want 1 %h", k, down_valid, down_data, exp);
                end
            end
            release_result();
        end
    endtask

    initial begin
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        up_amount  = '0;
        up_dir     = 1'b0;
        down_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_left();
        test_right();
        test_amount_edges();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
